// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg: shared types and sizing helpers for the L1 port arbiter.
// Revision: 1.0
`default_nettype none

package l1_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic owner_t;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Counter only has to reach TIMEOUT_CYCLES-1, so clog2 of the limit suffices.
    function automatic int timeout_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/l1_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; the port that was not last served wins a tie.
// Revision: 1.0
`default_nettype none

module rr_arb2
    import l1_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  owner_t     last_owner,
    output logic [1:0] gnt
);

    assign gnt[0] = req0 && (!req1 || (last_owner == 1'b1));
    assign gnt[1] = req1 && (!req0 || (last_owner == 1'b0));

endmodule

`default_nettype wire

// File: rtl/l1_port_arbiter.sv
// l1_port_arbiter: shares one L1 cache port between fetch (port 0) and load/store (port 1).
// Revision: 1.0
`default_nettype none

module l1_port_arbiter
    import l1_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,

    output logic              c_req,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wdata,
    input  logic              c_ready,
    input  logic              c_rvalid,
    input  logic [DATA_W-1:0] c_rdata
);

    localparam int              CNT_W    = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    owner_t           owner;
    owner_t           last_owner;
    logic [CNT_W-1:0] tmo_cnt;

    logic [1:0] pick;
    logic       idle;
    logic       busy;
    logic       complete;
    logic       expire;
    logic       finish;

    // Grants are only offered in IDLE and never while reset is held.
    assign idle = (state == IDLE) && !rst;

    rr_arb2 u_rr (
        .req0       (r0_req && idle),
        .req1       (r1_req && idle),
        .last_owner (last_owner),
        .gnt        (pick)
    );

    assign r0_gnt = pick[0];
    assign r1_gnt = pick[1];

    assign busy     = (state == ISSUE) || (state == WAIT);
    assign complete = ((state == ISSUE) && c_ready && c_rvalid) ||
                      ((state == WAIT) && c_rvalid);
    // A completion arriving on the last allowed cycle still wins over the timeout.
    assign expire   = busy && !complete && (tmo_cnt == CNT_LAST);
    assign finish   = complete || expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            tmo_cnt    <= '0;
            c_req      <= 1'b0;
            c_we       <= 1'b0;
            c_addr     <= '0;
            c_wdata    <= '0;
            r0_rvalid  <= 1'b0;
            r0_rdata   <= '0;
            r0_err     <= 1'b0;
            r1_rvalid  <= 1'b0;
            r1_rdata   <= '0;
            r1_err     <= 1'b0;
        end else begin
            r0_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r0_err    <= 1'b0;
            r1_rvalid <= 1'b0;
            r1_rdata  <= '0;
            r1_err    <= 1'b0;

            if (busy) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        owner      <= pick[1];
                        last_owner <= pick[1];
                        c_req      <= 1'b1;
                        c_we       <= pick[1] ? r1_we    : r0_we;
                        c_addr     <= pick[1] ? r1_addr  : r0_addr;
                        c_wdata    <= pick[1] ? r1_wdata : r0_wdata;
                        tmo_cnt    <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (finish || c_ready) begin
                        c_req   <= 1'b0;
                        c_we    <= 1'b0;
                        c_addr  <= '0;
                        c_wdata <= '0;
                        state   <= finish ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (finish) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (finish) begin
                if (owner == 1'b1) begin
                    r1_rvalid <= 1'b1;
                    r1_rdata  <= complete ? c_rdata : '0;
                    r1_err    <= !complete;
                end else begin
                    r0_rvalid <= 1'b1;
                    r0_rdata  <= complete ? c_rdata : '0;
                    r0_err    <= !complete;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l1_port_arbiter.sv
// tb_l1_port_arbiter: directed scoreboard bench for the L1 port arbiter.
// Revision: 1.0
`default_nettype none

module tb_l1_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_gnt, r0_rvalid, r0_err;
    logic [DW-1:0] r0_rdata;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_gnt, r1_rvalid, r1_err;
    logic [DW-1:0] r1_rdata;
    logic          c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_ready = 1'b0, c_rvalid = 1'b0;
    logic [DW-1:0] c_rdata = '0;

    always #5 clk = ~clk;

    l1_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ready(c_ready), .c_rvalid(c_rvalid), .c_rdata(c_rdata)
    );

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] mon_d;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_rsp(input logic p, input logic [DW-1:0] d, input logic e);
        sb.push_back('{port: p, data: d, err: e});
    endtask

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (p == 0) begin
            r0_req = v; r0_we = we; r0_addr = a; r0_wdata = wd;
        end else begin
            r1_req = v; r1_we = we; r1_addr = a; r1_wdata = wd;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? r0_gnt : r1_gnt;
    endfunction

    // Leaves the caller in the grant cycle; a missing grant gives up after 20 cycles.
    task automatic wait_grant(input int p, input int exp_wait);
        int n;
        n = 0;
        #1;
        while (gnt_of(p) !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk($sformatf("gnt_wait_p%0d", p), 64'(n), 64'(exp_wait));
        chk($sformatf("gnt_other_p%0d", p), 64'((p == 0) ? r1_gnt : r0_gnt), 64'h0);
    endtask

    task automatic chk_cache(input string tag, input logic we,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
        chk({tag, "_req"},   64'(c_req),   64'h1);
        chk({tag, "_we"},    64'(c_we),    64'(we));
        chk({tag, "_addr"},  64'(c_addr),  64'(a));
        chk({tag, "_wdata"}, 64'(c_wdata), 64'(wd));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({c_req, c_we, c_addr, c_wdata, r0_gnt, r1_gnt,
                                 r0_rvalid, r1_rvalid, r0_err, r1_err}), 64'h0);
        chk({tag, "_rdata"}, 64'({r0_rdata, r1_rdata}), 64'h0);
    endtask

    task automatic serve(input logic [DW-1:0] d);
        c_ready = 1'b1; c_rvalid = 1'b1; c_rdata = d;
        tick();
        c_ready = 1'b0; c_rvalid = 1'b0; c_rdata = '0;
    endtask

    // Response monitor: every rvalid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (r0_rvalid === 1'b1 || r1_rvalid === 1'b1) begin
            chk("rvalid_both", 64'(r0_rvalid & r1_rvalid), 64'h0);
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 64'({r0_rvalid, r1_rvalid}), 64'h0);
            end else begin
                mon_e = sb.pop_front();
                mon_d = mon_e.port ? r1_rdata : r0_rdata;
                chk("rsp_port", 64'(r1_rvalid), 64'(mon_e.port));
                chk("rsp_data", 64'(mon_d), 64'(mon_e.data));
                chk("rsp_err", 64'(mon_e.port ? r1_err : r0_err), 64'(mon_e.err));
            end
        end
        if (r0_rvalid !== 1'b1) chk("r0_quiet", 64'({r0_rdata, r0_err}), 64'h0);
        if (r1_rvalid !== 1'b1) chk("r1_quiet", 64'({r1_rdata, r1_err}), 64'h0);
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        // Reset: outputs quiet even with a request pending.
        r0_req = 1'b1;
        tick();
        #1;
        chk_zero("reset");
        r0_req = 1'b0;
        rst = 1'b0;

        // Single zero-wait read on port 0.
        tick();
        expect_rsp(1'b0, 16'hBEEF, 1'b0);
        set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        wait_grant(0, 0);
        tick();
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk_cache("t1_issue", 1'b0, 16'h0010, 16'h0000);
        serve(16'hBEEF);
        #1;
        chk("t1_rvalid_lat", 64'(r0_rvalid), 64'h1);
        chk("t1_rdata", 64'(r0_rdata), 64'hBEEF);
        chk("t1_creq_drop", 64'(c_req), 64'h0);
        tick();

        // Simultaneous requests after reset: port 0 first, port 1 right after.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_req(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        set_req(1, 1'b1, 1'b0, 16'h0200, 16'h0000);
        expect_rsp(1'b0, 16'hA000, 1'b0);
        wait_grant(0, 0);
        tick();
        set_req(0, 1'b0, 1'b0, 16'h0100, 16'h0000);
        #1;
        chk("t2_addr0", 64'(c_addr), 64'h0100);
        serve(16'hA000);
        #1;
        chk("t2_r1_pending", 64'(r1_gnt), 64'h0);
        expect_rsp(1'b1, 16'hA001, 1'b0);
        tick();
        wait_grant(1, 0);
        tick();
        #1;
        chk("t2_addr1", 64'(c_addr), 64'h0200);
        serve(16'hA001);
        tick();

        // Both held: grants alternate 0,1,0,1.
        set_req(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            expect_rsp(1'(k % 2), 16'hB000 + 16'(k), 1'b0);
            wait_grant(k % 2, 0);
            tick();
            #1;
            chk($sformatf("t2_alt_addr%0d", k), 64'(c_addr), (k % 2 == 1) ? 64'h0200 : 64'h0100);
            serve(16'hB000 + 16'(k));
            tick();
        end

        // Port 1 write with c_ready withheld for three cycles.
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_req(1, 1'b1, 1'b1, 16'h1234, 16'h5A5A);
        expect_rsp(1'b1, 16'h0F0F, 1'b0);
        wait_grant(1, 0);
        tick();
        set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_cache($sformatf("t3_hold%0d", i), 1'b1, 16'h1234, 16'h5A5A);
            if (i == 3) c_ready = 1'b1;
            tick();
        end
        c_ready = 1'b0;
        #1;
        chk("t3_wait_creq", 64'(c_req), 64'h0);
        chk("t3_wait_rvalid", 64'(r1_rvalid), 64'h0);
        tick();
        tick();
        c_rvalid = 1'b1; c_rdata = 16'h0F0F;
        tick();
        c_rvalid = 1'b0; c_rdata = '0;
        #1;
        chk("t3_rvalid", 64'(r1_rvalid), 64'h1);
        chk("t3_rdata", 64'(r1_rdata), 64'h0F0F);
        tick();

        // Timeout: cache never answers.
        set_req(0, 1'b1, 1'b0, 16'h0044, 16'h0000);
        expect_rsp(1'b0, 16'h0000, 1'b1);
        wait_grant(0, 0);
        tick();
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < TO; i++) begin
            #1;
            chk($sformatf("t4_issue%0d", i), 64'(c_req), 64'h1);
            tick();
        end
        #1;
        chk("t4_creq_drop", 64'(c_req), 64'h0);
        chk("t4_rvalid", 64'(r0_rvalid), 64'h1);
        chk("t4_err", 64'(r0_err), 64'h1);
        chk("t4_rdata", 64'(r0_rdata), 64'h0);
        tick();
        tick();
        tick();
        c_rvalid = 1'b1; c_rdata = 16'hDEAD;
        tick();
        c_rvalid = 1'b0; c_rdata = '0;
        #1;
        chk("t4_late_ignored", 64'(r0_rvalid), 64'h0);
        tick();

        // Reset while in WAIT, with a cache response arriving during reset.
        set_req(0, 1'b1, 1'b0, 16'h0066, 16'h0000);
        wait_grant(0, 0);
        tick();
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        #1;
        chk("t5_wait_creq", 64'(c_req), 64'h0);
        tick();
        rst = 1'b1;
        c_rvalid = 1'b1; c_rdata = 16'h1234;
        #1;
        chk_zero("t5_rst_wait");
        tick();
        c_rvalid = 1'b0; c_rdata = '0;
        rst = 1'b0;
        tick();
        c_rvalid = 1'b1; c_rdata = 16'h4321;
        tick();
        c_rvalid = 1'b0; c_rdata = '0;

        // Reset while in ISSUE drops c_req at once.
        set_req(0, 1'b1, 1'b0, 16'h0055, 16'h0000);
        wait_grant(0, 0);
        tick();
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk("t5_issue_creq", 64'(c_req), 64'h1);
        rst = 1'b1;
        #1;
        chk("t5_issue_rst", 64'(c_req), 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // Normal service after reset.
        set_req(1, 1'b1, 1'b0, 16'h0077, 16'h0000);
        expect_rsp(1'b1, 16'h1111, 1'b0);
        wait_grant(1, 0);
        tick();
        set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk_cache("t5_after", 1'b0, 16'h0077, 16'h0000);
        serve(16'h1111);
        #1;
        chk("t5_after_rvalid", 64'(r1_rvalid), 64'h1);
        tick();

        // Port 1 held continuously, port 0 re-requests every IDLE: strict alternation.
        set_req(1, 1'b1, 1'b0, 16'h0300, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, 1'b0, 16'h0400 + 16'(k), 16'h0000);
            expect_rsp(1'(k % 2), 16'hC000 + 16'(k), 1'b0);
            wait_grant(k % 2, 0);
            tick();
            set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            #1;
            chk($sformatf("t6_addr%0d", k), 64'(c_addr),
                (k % 2 == 1) ? 64'h0300 : 64'(16'h0400 + 16'(k)));
            c_ready = 1'b1;
            tick();
            c_ready = 1'b0;
            c_rvalid = 1'b1; c_rdata = 16'hC000 + 16'(k);
            tick();
            c_rvalid = 1'b0; c_rdata = '0;
            tick();
        end
        set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
